// File: rtl/bcd_count_0to19_pkg.sv
// Shared types and helpers for the BCD 0..MAX counter and its button conditioning.
package bcd_counter_pkg;

    // Control states of the counter.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // One decimal digit, always kept within 0..9.
    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_NINE = 4'd9;

    // Two-digit packed value as presented to the scan driver: tens in [7:4], ones in [3:0].
    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd_pair_t;

    localparam bcd_pair_t BCD_ZERO = '0;

    // Converts a binary value (0..99) into its two-digit BCD form; used to build the terminal value.
    function automatic bcd_pair_t bin_to_bcd_pair(input int unsigned value);
        bcd_pair_t r;
        r.tens = bcd_digit_t'((value / 10) % 10);
        r.ones = bcd_digit_t'(value % 10);
        return r;
    endfunction

    // Decimal increment of a two-digit BCD value; 99 rolls to 00.
    function automatic bcd_pair_t bcd_pair_incr(input bcd_pair_t p);
        bcd_pair_t r;
        r = p;
        if (p.ones == BCD_NINE) begin
            r.ones = '0;
            if (p.tens == BCD_NINE) begin
                r.tens = '0;
            end else begin
                r.tens = p.tens + 4'd1;
            end
        end else begin
            r.ones = p.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_count_0to19_btn_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, stability counter and a
// one-cycle press strobe on the accepted 0->1 edge of the debounced level.
module btn_debounce
    import bcd_counter_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 20_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    // Counter only has to reach DEB_CYCLES-1; acceptance happens on that sample.
    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    logic w_differ;
    logic w_accept;

    assign w_differ = r_sync2 ^ r_level;
    assign w_accept = w_differ && (r_cnt == CNT_LAST);

    // Two-stage synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Counts consecutive samples disagreeing with the debounced level; any agreement restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!w_differ || w_accept) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Accepts the new level after DEB_CYCLES disagreeing samples and strobes on an accepted rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            if (w_accept) begin
                r_level <= r_sync2;
            end
            r_press <= w_accept && r_sync2;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/bcd_count_0to19.sv
// Two-digit BCD counter (00..MAX_COUNT) advanced by a prescaled tick, with
// debounced run/pause and clear buttons. Output feeds the seven-segment scan driver.
module bcd_count_0to19
    import bcd_counter_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1_000_000,
    parameter int unsigned DEB_CYCLES = 20_000,
    parameter int unsigned MAX_COUNT  = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_run,
    input  logic       btn_clr,
    output logic [7:0] bcd_num,
    output logic       running,
    output logic       wrap_pulse
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam bcd_pair_t MAX_BCD = bin_to_bcd_pair(MAX_COUNT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PRE_W-1:0] r_presc;
    bcd_pair_t        r_count;
    logic             r_running;
    logic             r_wrap;

    logic w_run_press;
    logic w_clr_press;
    logic w_tick;
    logic w_at_max;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_run_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (btn_run),
        .o_press(w_run_press)
    );

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_clr_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_btn  (btn_clr),
        .o_press(w_clr_press)
    );

    assign w_tick   = (r_state == RUN) && (r_presc == PRE_LAST);
    assign w_at_max = (r_count == MAX_BCD);

    // Next-state: clear dominates; run press toggles between RUN and PAUSE, starts from IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clr_press) begin
            w_state_nxt = IDLE;
        end else if (w_run_press) begin
            unique case (r_state)
                IDLE:    w_state_nxt = RUN;
                RUN:     w_state_nxt = PAUSE;
                PAUSE:   w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register; running is registered alongside so it tracks the state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == RUN);
        end
    end

    // Prescaler: advances only in RUN, frozen in PAUSE, forced to zero in IDLE or on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_clr_press || (r_state == IDLE)) begin
            r_presc <= '0;
        end else if (r_state == RUN) begin
            if (w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end
        end
    end

    // Count update on tick with wrap at MAX_COUNT; clear overrides a coincident tick and its wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= BCD_ZERO;
            r_wrap  <= 1'b0;
        end else if (w_clr_press) begin
            r_count <= BCD_ZERO;
            r_wrap  <= 1'b0;
        end else if (w_tick) begin
            if (w_at_max) begin
                r_count <= BCD_ZERO;
                r_wrap  <= 1'b1;
            end else begin
                r_count <= bcd_pair_incr(r_count);
                r_wrap  <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign bcd_num    = r_count;
    assign running    = r_running;
    assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_bcd_count_0to19.sv
// Bench for bcd_count_0to19: directed vector table, hand-written reset sequence,
// and randomized button stimulus compared each cycle against a behavioural model.
module tb_bcd_count_0to19;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned DEB_CYCLES = 3;
    localparam int unsigned MAX_COUNT  = 19;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_run = 1'b0;
    logic       btn_clr = 1'b0;
    logic [7:0] bcd_num;
    logic       running;
    logic       wrap_pulse;

    bcd_count_0to19 #(
        .TICK_DIV  (TICK_DIV),
        .DEB_CYCLES(DEB_CYCLES),
        .MAX_COUNT (MAX_COUNT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_run   (btn_run),
        .btn_clr   (btn_clr),
        .bcd_num   (bcd_num),
        .running   (running),
        .wrap_pulse(wrap_pulse)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int wraps = 0;
    bit seen [256];

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
    int m_mode, m_val, m_elapsed;
    bit m_wrap, m_running;
    // raw button history, bit j = raw value sampled j edges ago
    bit [DEB_CYCLES+1:0] h_run, h_clr;
    bit l_run, l_clr, p_run, p_clr;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_val = 0; m_elapsed = 0; m_wrap = 0; m_running = 0;
        h_run = '0; h_clr = '0; l_run = 0; l_clr = 0; p_run = 0; p_clr = 0;
    endtask

    // Level flips once the synchronised samples (raw delayed by two edges) of the
    // last DEB_CYCLES edges all disagree with it.
    task automatic deb(input bit [DEB_CYCLES+1:0] h, input bit lvl, output bit nlvl, output bit press);
        bit [DEB_CYCLES-1:0] win;
        win = h[DEB_CYCLES+1:2];
        nlvl = lvl;
        if (lvl ? (win == '0) : (win == '1)) nlvl = !lvl;
        press = !lvl && nlvl;
    endtask

    task automatic model_edge(input bit raw_run, input bit raw_clr);
        bit tick, nl, pr;
        tick = (m_mode == M_RUN) && (m_elapsed == int'(TICK_DIV) - 1);
        m_wrap = 0;
        if (p_clr) begin
            m_mode = M_IDLE; m_val = 0; m_elapsed = 0;
        end else begin
            if (tick) begin
                m_wrap = (m_val == int'(MAX_COUNT));
                m_val = m_wrap ? 0 : m_val + 1;
                m_elapsed = 0;
            end else if (m_mode == M_RUN) begin
                m_elapsed++;
            end
            if (p_run) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
        end
        m_running = (m_mode == M_RUN);
        h_run = {h_run[DEB_CYCLES:0], raw_run};
        h_clr = {h_clr[DEB_CYCLES:0], raw_clr};
        deb(h_run, l_run, nl, pr); l_run = nl; p_run = pr;
        deb(h_clr, l_clr, nl, pr); l_clr = nl; p_clr = pr;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(btn_run, btn_clr);
        @(negedge clk);
        cmp("cycle", {22'b0, bcd_num, running, wrap_pulse}, {22'b0, to_bcd(m_val), m_running, m_wrap});
        if (wrap_pulse === 1'b1) wraps++;
        if (!$isunknown(bcd_num)) seen[bcd_num] = 1'b1;
    endtask

    function automatic int n_distinct();
        int n = 0;
        for (int i = 0; i < 256; i++) if (seen[i]) n++;
        return n;
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        bit          run;
        bit          clr;
        int unsigned n;
        logic [7:0]  bcd;
        bit          run_o;
    } vec_t;
    vec_t tbl[$];

    initial begin
        tbl.push_back(vec_t'{1'b0, 1'b0, 100, 8'h00, 1'b0}); // idle after reset
        tbl.push_back(vec_t'{1'b1, 1'b0,   5, 8'h00, 1'b0}); // press not yet acted on
        tbl.push_back(vec_t'{1'b1, 1'b0,   1, 8'h00, 1'b1}); // RUN 6 edges after raise
        tbl.push_back(vec_t'{1'b1, 1'b0,   4, 8'h01, 1'b1}); // first increment TICK_DIV later, held button
        tbl.push_back(vec_t'{1'b0, 1'b0,   4, 8'h02, 1'b1});
        tbl.push_back(vec_t'{1'b0, 1'b0,  32, 8'h10, 1'b1}); // through 09->10
        tbl.push_back(vec_t'{1'b0, 1'b0,  36, 8'h19, 1'b1});
        tbl.push_back(vec_t'{1'b0, 1'b0,   4, 8'h00, 1'b1}); // wrap
        tbl.push_back(vec_t'{1'b0, 1'b0,  24, 8'h06, 1'b1});
        tbl.push_back(vec_t'{1'b1, 1'b0,   6, 8'h07, 1'b0}); // paused at 07, prescaler 2
        tbl.push_back(vec_t'{1'b1, 1'b0,  50, 8'h07, 1'b0}); // frozen
        tbl.push_back(vec_t'{1'b0, 1'b0,  10, 8'h07, 1'b0});
        tbl.push_back(vec_t'{1'b1, 1'b0,   7, 8'h07, 1'b1}); // resumed, partial period left
        tbl.push_back(vec_t'{1'b1, 1'b0,   1, 8'h08, 1'b1}); // increment 2 cycles after resume
        tbl.push_back(vec_t'{1'b0, 1'b0,  10, 8'h10, 1'b1});
        tbl.push_back(vec_t'{1'b1, 1'b0,   2, 8'h11, 1'b1}); // 2-cycle glitches
        tbl.push_back(vec_t'{1'b0, 1'b0,   2, 8'h11, 1'b1});
        tbl.push_back(vec_t'{1'b1, 1'b0,   2, 8'h12, 1'b1});
        tbl.push_back(vec_t'{1'b0, 1'b0,   2, 8'h12, 1'b1});
        tbl.push_back(vec_t'{1'b1, 1'b1,   5, 8'h13, 1'b1}); // both pressed together at 13
        tbl.push_back(vec_t'{1'b1, 1'b1,   1, 8'h00, 1'b0}); // clear wins over run and tick
        tbl.push_back(vec_t'{1'b0, 1'b0,  20, 8'h00, 1'b0});
        tbl.push_back(vec_t'{1'b1, 1'b0,   6, 8'h00, 1'b1});
        tbl.push_back(vec_t'{1'b0, 1'b0,  64, 8'h16, 1'b1});

        #2;
        cmp("reset_state", {22'b0, bcd_num, running, wrap_pulse}, 32'h0);
        model_reset();
        #10 rst_n = 1'b1;
        wraps = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            btn_run = tbl[i].run;
            btn_clr = tbl[i].clr;
            repeat (tbl[i].n) cycle();
            cmp($sformatf("vec%0d_bcd", i), {24'b0, bcd_num}, {24'b0, tbl[i].bcd});
            cmp($sformatf("vec%0d_running", i), {31'b0, running}, {31'b0, tbl[i].run_o});
            if (i == 7) begin
                cmp("lap_wraps", wraps, 1);
                cmp("lap_distinct", n_distinct(), 20);
            end
        end

        // asynchronous reset between clock edges at 16
        #2 rst_n = 1'b0;
        #1 cmp("async_reset", {22'b0, bcd_num, running, wrap_pulse}, 32'h0);
        model_reset();
        repeat (3) cycle();
        #2 rst_n = 1'b1;
        repeat (20) cycle();
        cmp("post_reset_bcd", {24'b0, bcd_num}, 32'h0);
        cmp("post_reset_running", {31'b0, running}, 32'h0);
        btn_run = 1'b1;
        repeat (10) cycle();
        cmp("post_reset_first_tick", {24'b0, bcd_num}, 32'h01);
        btn_run = 1'b0;
        btn_clr = 1'b0;
        repeat (10) cycle();

        // randomized button activity against the model
        for (int s = 0; s < 400; s++) begin
            btn_run = 1'($urandom_range(0, 1));
            btn_clr = ($urandom_range(0, 15) == 0);
            repeat ($urandom_range(1, 12)) cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
